// File: rtl/iq_clock_phase_shifter_if.sv
// Run-control and clock-output bundle for iq_clock_phase_shifter.
// Defining IQ_DIFF_OUT_EN adds the complementary clock outputs.
interface iq_clock_phase_shifter_if;
  logic i_enable;
  logic i_swap_iq;
  logic o_clk_i;
  logic o_clk_q;
  logic o_running;
`ifdef IQ_DIFF_OUT_EN
  logic o_clk_i_n;
  logic o_clk_q_n;

  modport master (
    output i_enable, i_swap_iq,
    input  o_clk_i, o_clk_q, o_running, o_clk_i_n, o_clk_q_n
  );

  modport slave (
    input  i_enable, i_swap_iq,
    output o_clk_i, o_clk_q, o_running, o_clk_i_n, o_clk_q_n
  );
`else
  modport master (
    output i_enable, i_swap_iq,
    input  o_clk_i, o_clk_q, o_running
  );

  modport slave (
    input  i_enable, i_swap_iq,
    output o_clk_i, o_clk_q, o_running
  );
`endif
endinterface

// File: rtl/iq_clock_phase_shifter.sv
// Quadrature (I/Q) clock generator: divides i_clk_2f by 2*HALF_PERIOD, Q lags I by 90 deg.
// Optional IQ_DIFF_OUT_EN adds gated complementary outputs o_clk_i_n / o_clk_q_n.
module iq_clock_phase_shifter #(
  parameter int HALF_PERIOD = 1,
  parameter int CNT_W       = 8
) (
  input logic                     i_clk_2f,
  input logic                     i_reset,
  iq_clock_phase_shifter_if.slave bus
);

  localparam int DLY   = HALF_PERIOD / 2;
  localparam int DLY_W = (DLY > 0) ? DLY : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             i_q, i_d;
  logic             swap_q, swap_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             q_tap;
  logic             q_lag;
  logic             running;
  logic             q_out;

  // The start edge is itself an I toggle, so the counter restarts from 0 and
  // the first half-period is full length like every later one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    swap_d  = swap_q;
    dly_d   = '0;
    case (state_q)
      ST_STOPPED: begin
        cnt_d = '0;
        i_d   = 1'b0;
        if (bus.i_enable) begin
          state_d = ST_RUNNING;
          i_d     = 1'b1;
        end else begin
          swap_d = bus.i_swap_iq;
        end
      end
      ST_RUNNING: begin
        if (!bus.i_enable) begin
          state_d = ST_STOPPED;
          i_d     = 1'b0;
          cnt_d   = '0;
        end else begin
          dly_d = DLY_W'({dly_q, i_q});
          if (cnt_q == CNT_LAST) begin
            i_d   = ~i_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge i_clk_2f) begin
    if (i_reset) begin
      state_q <= ST_STOPPED;
      cnt_q   <= '0;
      i_q     <= 1'b0;
      swap_q  <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      swap_q  <= swap_d;
      dly_q   <= dly_d;
    end
  end

  assign q_tap = (DLY == 0) ? i_q : dly_q[DLY_W-1];

  // Odd half-periods need the extra half input cycle from a falling-edge stage.
  if (HALF_PERIOD % 2 == 1) begin : g_odd
    logic neg_q, neg_d;

    always_comb begin
      neg_d = q_tap;
    end

    always_ff @(negedge i_clk_2f) begin
      if (i_reset) neg_q <= 1'b0;
      else         neg_q <= neg_d;
    end

    assign q_lag = neg_q;
  end else begin : g_even
    assign q_lag = q_tap;
  end

  // Gating with running also hides the falling-edge stage in the half cycle after a stop.
  assign running       = (state_q == ST_RUNNING);
  assign q_out         = running & (q_lag ^ swap_q);
  assign bus.o_clk_i   = i_q;
  assign bus.o_clk_q   = q_out;
  assign bus.o_running = running;
`ifdef IQ_DIFF_OUT_EN
  assign bus.o_clk_i_n = running & ~i_q;
  assign bus.o_clk_q_n = running & ~q_out;
`endif

endmodule

// File: tb/tb_iq_clock_phase_shifter.sv
// Directed bench for iq_clock_phase_shifter: three instances (HALF_PERIOD 1, 4, 3)
// share clock and reset; one instance at a time is driven and checked.
module tb_iq_clock_phase_shifter;

  logic       clk;
  logic       rst;
  logic [2:0] en_vec;
  logic [2:0] swap_vec;
  logic [2:0] out_i, out_q, out_run;

  int tests_run;
  int tests_failed;

  iq_clock_phase_shifter_if bus0 ();
  iq_clock_phase_shifter_if bus1 ();
  iq_clock_phase_shifter_if bus2 ();

  iq_clock_phase_shifter #(.HALF_PERIOD(1), .CNT_W(8)) dut_h1 (
    .i_clk_2f(clk), .i_reset(rst), .bus(bus0)
  );
  iq_clock_phase_shifter #(.HALF_PERIOD(4), .CNT_W(8)) dut_h4 (
    .i_clk_2f(clk), .i_reset(rst), .bus(bus1)
  );
  iq_clock_phase_shifter #(.HALF_PERIOD(3), .CNT_W(8)) dut_h3 (
    .i_clk_2f(clk), .i_reset(rst), .bus(bus2)
  );

  assign bus0.i_enable  = en_vec[0];
  assign bus1.i_enable  = en_vec[1];
  assign bus2.i_enable  = en_vec[2];
  assign bus0.i_swap_iq = swap_vec[0];
  assign bus1.i_swap_iq = swap_vec[1];
  assign bus2.i_swap_iq = swap_vec[2];
  assign out_i   = {bus2.o_clk_i,   bus1.o_clk_i,   bus0.o_clk_i};
  assign out_q   = {bus2.o_clk_q,   bus1.o_clk_q,   bus0.o_clk_q};
  assign out_run = {bus2.o_running, bus1.o_running, bus0.o_running};
`ifdef IQ_DIFF_OUT_EN
  logic [2:0] out_i_n, out_q_n;
  assign out_i_n = {bus2.o_clk_i_n, bus1.o_clk_i_n, bus0.o_clk_i_n};
  assign out_q_n = {bus2.o_clk_q_n, bus1.o_clk_q_n, bus0.o_clk_q_n};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per posedge: inputs, then I / Q / running just after the posedge
  // and Q again just after the following negedge.
  typedef struct {
    int   sel;
    logic rst;
    logic en;
    logic swap;
    logic exp_i;
    logic exp_q_pos;
    logic exp_q_neg;
    logic exp_run;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input int sel, input logic r, input logic en,
                                 input logic sw, input logic ei, input logic eqp,
                                 input logic eqn, input logic er);
    vec_t v;
    v.sel = sel; v.rst = r; v.en = en; v.swap = sw;
    v.exp_i = ei; v.exp_q_pos = eqp; v.exp_q_neg = eqn; v.exp_run = er;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input int sel, input logic r, input logic en, input logic sw);
    en_vec        = '0;
    swap_vec      = '0;
    en_vec[sel]   = en;
    swap_vec[sel] = sw;
    rst           = r;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkDiff(input string name, input int sel, input logic exp_i,
                           input logic exp_q, input logic exp_run);
`ifdef IQ_DIFF_OUT_EN
    checkOutput({name, "_i_n"}, out_i_n[sel], exp_run & ~exp_i);
    checkOutput({name, "_q_n"}, out_q_n[sel], exp_run & ~exp_q);
`else
    if (sel < 0) $display("[TB] %s %b %b %b", name, exp_i, exp_q, exp_run);
`endif
  endtask

  initial begin
    int   i_highs;
    int   q_highs;
    int   i_errs;
    int   q_errs;
    logic exp_hist[$];

    tests_run    = 0;
    tests_failed = 0;
    en_vec       = '0;
    swap_vec     = '0;
    rst          = 1'b1;

    // Reset state of each instance
    addVec(0,1,0,0, 0,0,0,0);
    addVec(1,1,0,0, 0,0,0,0);
    addVec(2,1,0,0, 0,0,0,0);
    // HALF_PERIOD=1: I toggles every edge, Q follows half a cycle later
    addVec(0,0,1,0, 1,0,1,1);
    addVec(0,0,1,0, 0,1,0,1);
    addVec(0,0,1,0, 1,0,1,1);
    addVec(0,0,1,0, 0,1,0,1);
    addVec(0,0,0,0, 0,0,0,0);
    addVec(0,0,0,0, 0,0,0,0);
    // HALF_PERIOD=4: 4 high / 4 low, Q two edges behind
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 1,1,1,1);
    addVec(1,0,1,0, 1,1,1,1);
    addVec(1,0,1,0, 0,1,1,1);
    addVec(1,0,1,0, 0,1,1,1);
    addVec(1,0,1,0, 0,0,0,1);
    addVec(1,0,1,0, 0,0,0,1);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 1,0,0,1);
    // drop enable mid-high, stay idle, restart from phase zero
    addVec(1,0,0,0, 0,0,0,0);
    addVec(1,0,0,0, 0,0,0,0);
    addVec(1,0,0,0, 0,0,0,0);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 1,1,1,1);
    addVec(1,0,1,0, 1,1,1,1);
    addVec(1,0,1,0, 0,1,1,1);
    // swap latched while stopped; mid-run swap change ignored
    addVec(1,0,0,1, 0,0,0,0);
    addVec(1,0,0,1, 0,0,0,0);
    addVec(1,0,1,1, 1,1,1,1);
    addVec(1,0,1,1, 1,1,1,1);
    addVec(1,0,1,1, 1,0,0,1);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 0,0,0,1);
    addVec(1,0,1,0, 0,0,0,1);
    addVec(1,0,1,0, 0,1,1,1);
    addVec(1,0,1,0, 0,1,1,1);
    addVec(1,0,1,0, 1,1,1,1);
    addVec(1,0,1,0, 1,1,1,1);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,0,0, 0,0,0,0);
    addVec(1,0,0,0, 0,0,0,0);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 1,0,0,1);
    addVec(1,0,1,0, 1,1,1,1);
    // HALF_PERIOD=3: period 6, Q edges 1.5 cycles after I edges
    addVec(2,0,0,0, 0,0,0,0);
    addVec(2,0,1,0, 1,0,0,1);
    addVec(2,0,1,0, 1,0,1,1);
    addVec(2,0,1,0, 1,1,1,1);
    addVec(2,0,1,0, 0,1,1,1);
    addVec(2,0,1,0, 0,1,0,1);
    addVec(2,0,1,0, 0,0,0,1);
    addVec(2,0,1,0, 1,0,0,1);
    addVec(2,0,1,0, 1,0,1,1);
    addVec(2,0,0,1, 0,0,0,0);
    addVec(2,0,0,1, 0,0,0,0);
    // swapped run, then reset with enable and swap still high
    addVec(2,0,1,1, 1,1,1,1);
    addVec(2,0,1,1, 1,1,0,1);
    addVec(2,0,1,1, 1,0,0,1);
    addVec(2,0,1,1, 0,0,0,1);
    addVec(2,0,1,1, 0,0,1,1);
    addVec(2,1,1,1, 0,0,0,0);
    addVec(2,0,1,1, 1,0,0,1);
    addVec(2,0,1,1, 1,0,1,1);
    addVec(2,0,1,1, 1,1,1,1);
    addVec(2,0,1,1, 0,1,1,1);
    addVec(2,0,1,1, 0,1,0,1);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].sel, vecs[k].rst, vecs[k].en, vecs[k].swap);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_i", k),     out_i[vecs[k].sel],   vecs[k].exp_i);
      checkOutput($sformatf("v%0d_q_pos", k), out_q[vecs[k].sel],   vecs[k].exp_q_pos);
      checkOutput($sformatf("v%0d_run", k),   out_run[vecs[k].sel], vecs[k].exp_run);
      checkDiff($sformatf("v%0d", k), vecs[k].sel, vecs[k].exp_i,
                vecs[k].exp_q_pos, vecs[k].exp_run);
      @(negedge clk);
      #1;
      checkOutput($sformatf("v%0d_q_neg", k), out_q[vecs[k].sel],   vecs[k].exp_q_neg);
    end

    // HALF_PERIOD=4 over ten full periods from a fresh start
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    i_highs = 0;
    q_highs = 0;
    i_errs  = 0;
    q_errs  = 0;
    exp_hist.delete();
    for (int k = 0; k < 80; k++) begin
      logic ei;
      logic eq;
      ei = (((k / 4) % 2) == 0);
      eq = (k >= 2) ? exp_hist[k-2] : 1'b0;
      exp_hist.push_back(ei);
      applyStimulus(1, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      if (out_i[1] === 1'b1) i_highs++;
      if (out_q[1] === 1'b1) q_highs++;
      if (out_i[1] !== ei) i_errs++;
      if (out_q[1] !== eq) q_errs++;
      @(negedge clk);
    end
    checkCount("duty_i_high_cycles", i_highs, 40);
    checkCount("duty_q_high_cycles", q_highs, 40);
    checkCount("i_waveform_bad_edges", i_errs, 0);
    checkCount("q_lag2_bad_edges", q_errs, 0);

    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("final_stop_i", out_i[1], 1'b0);
    checkOutput("final_stop_q", out_q[1], 1'b0);
    checkOutput("final_stop_run", out_run[1], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
